// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_arbiter
//  Purpose  : Round-robin (with lock) arbiter sharing one register-file port
//             among Nreq requesters, with in-order response routing.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_arbiter #(
    parameter int Naddr = 4,
    parameter int Nreq  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [Nreq-1:0]             req_valid,
    input  logic [Nreq-1:0][Naddr-1:0]  req_addr,
    input  logic [Nreq-1:0][31:0]       req_wdata,
    input  logic [Nreq-1:0][3:0]        req_we,
    input  logic [Nreq-1:0]             req_lock,
    output logic [Nreq-1:0]             req_ready,
    output logic [Nreq-1:0]             rsp_valid,
    output logic [31:0]                 rsp_data,
    output logic [Naddr-1:0]            addr,
    output logic [31:0]                 wr_data,
    output logic                        en,
    output logic [3:0]                  we,
    input  logic [31:0]                 rd_data
);

    localparam int LW = (Nreq > 1) ? $clog2(Nreq) : 1;

    logic [LW-1:0]    r_last;
    logic [LW-1:0]    w_win;
    logic             w_found;
    logic             w_xfer;
    logic [Nreq-1:0]  w_ready;

    logic             r_en;
    logic [Naddr-1:0] r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_we;
    logic [LW-1:0]    r_idx1;
    logic             r_v2;
    logic [LW-1:0]    r_idx2;

    // Scan from last+Nreq down to last+1 so the earliest valid in round-robin
    // order is the final assignment; a held lock then overrides the scan.
    always_comb begin
        int idx;
        w_win   = r_last;
        w_found = 1'b0;
        idx     = 0;
        for (int k = Nreq; k >= 1; k--) begin
            idx = (int'(r_last) + k) % Nreq;
            if (req_valid[idx]) begin
                w_win   = LW'(idx);
                w_found = 1'b1;
            end
        end
        if (req_lock[r_last] && req_valid[r_last]) begin
            w_win   = r_last;
            w_found = 1'b1;
        end
        w_ready = '0;
        if (w_found && !reset) begin
            w_ready[w_win] = 1'b1;
        end
    end

    assign req_ready = w_ready;
    assign w_xfer    = |(req_valid & w_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last  <= LW'(Nreq - 1);
            r_en    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= '0;
            r_idx1  <= '0;
            r_v2    <= 1'b0;
            r_idx2  <= '0;
        end else begin
            if (w_xfer) begin
                r_last  <= w_win;
                r_en    <= 1'b1;
                r_addr  <= req_addr[w_win];
                r_wdata <= req_wdata[w_win];
                r_we    <= req_we[w_win];
                r_idx1  <= w_win;
            end else begin
                r_en    <= 1'b0;
                r_we    <= '0;
            end
            r_v2   <= r_en;
            r_idx2 <= r_idx1;
        end
    end

    // Outputs are forced quiet while reset is held, not just after the edge.
    assign en      = r_en & ~reset;
    assign we      = reset ? 4'b0 : r_we;
    assign addr    = reset ? '0 : r_addr;
    assign wr_data = reset ? 32'b0 : r_wdata;

    always_comb begin
        rsp_valid = '0;
        if (r_v2 && !reset) begin
            rsp_valid[r_idx2] = 1'b1;
        end
    end

    assign rsp_data = (r_v2 && !reset) ? rd_data : 32'b0;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_arbiter
//  Purpose  : Directed vector bench for regfile_arbiter with a small
//             register-file model behind the shared port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_arbiter;

    logic              clk;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0][3:0]   req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0][3:0]   req_we;
    logic [1:0]        req_lock;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_data;
    logic [3:0]        addr;
    logic [31:0]       wr_data;
    logic              en;
    logic [3:0]        we;
    logic [31:0]       rd_data;

    int errors = 0;
    int checks = 0;

    regfile_arbiter #(.Naddr(4), .Nreq(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .addr      (addr),
        .wr_data   (wr_data),
        .en        (en),
        .we        (we),
        .rd_data   (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: read data one cycle after en, byte-enabled write.
    logic [31:0] mem [16];
    logic [31:0] rd_q;
    assign rd_data = rd_q;

    initial begin
        rd_q = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 | i;
        mem[3] = 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (en) begin
            rd_q <= mem[addr];
            for (int b = 0; b < 4; b++) begin
                if (we[b]) mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [1:0]  lock;
        logic [3:0]  a0, a1;
        logic [3:0]  we0, we1;
        logic [31:0] wd0, wd1;
        logic [1:0]  e_ready;
        logic        e_en;
        logic [3:0]  e_addr;
        logic [3:0]  e_we;
        logic [31:0] e_wd;
        logic [1:0]  e_rv;
        logic [31:0] e_rd;
        logic        cad;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic [1:0] valid, input logic [1:0] lock,
        input logic [3:0] a0, input logic [3:0] a1,
        input logic [3:0] we0, input logic [3:0] we1,
        input logic [31:0] wd0, input logic [31:0] wd1,
        input logic [1:0] e_ready, input logic e_en, input logic [3:0] e_addr,
        input logic [3:0] e_we, input logic [31:0] e_wd,
        input logic [1:0] e_rv, input logic [31:0] e_rd, input logic cad);
        vec_t v;
        v.rst = rst; v.valid = valid; v.lock = lock; v.a0 = a0; v.a1 = a1;
        v.we0 = we0; v.we1 = we1; v.wd0 = wd0; v.wd1 = wd1;
        v.e_ready = e_ready; v.e_en = e_en; v.e_addr = e_addr; v.e_we = e_we;
        v.e_wd = e_wd; v.e_rv = e_rv; v.e_rd = e_rd; v.cad = cad;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] valid, input logic [1:0] lock,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] we0, input logic [3:0] we1,
                         input logic [31:0] wd0, input logic [31:0] wd1);
        reset        = rst;
        req_valid    = valid;
        req_lock     = lock;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_we[0]    = we0;
        req_we[1]    = we1;
        req_wdata[0] = wd0;
        req_wdata[1] = wd1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Checks the quiet-port condition used by idle and post-reset cycles.
    task automatic chk_quiet(input string tag);
        chk({tag, " ready"}, 32'(req_ready), 32'h0);
        chk({tag, " en"},    32'(en),        32'h0);
        chk({tag, " we"},    32'(we),        32'h0);
        chk({tag, " rv"},    32'(rsp_valid), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        drive(1'b1, 2'b00, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // rst valid lock a0 a1 we0 we1 wd0 wd1 | ready en addr we wd rv rd cad
        tbl.push_back(mk(1,2'b11,2'b00,0,0,0,0,0,0, 2'b00,0,0,0,0,2'b00,0,1));
        // single read
        tbl.push_back(mk(0,2'b01,2'b00,3,0,0,0,0,0, 2'b01,0,0,0,0,2'b00,0,0));
        tbl.push_back(mk(0,2'b00,2'b00,3,0,0,0,0,0, 2'b00,1,3,0,0,2'b00,0,1));
        tbl.push_back(mk(0,2'b00,2'b00,3,0,0,0,0,0, 2'b00,0,0,0,0,2'b01,32'hDEADBEEF,0));
        tbl.push_back(mk(1,2'b00,2'b00,0,0,0,0,0,0, 2'b00,0,0,0,0,2'b00,0,1));
        // fairness from reset
        tbl.push_back(mk(0,2'b11,2'b00,1,2,0,0,0,0, 2'b01,0,0,0,0,2'b00,0,0));
        tbl.push_back(mk(0,2'b11,2'b00,1,2,0,0,0,0, 2'b10,1,1,0,0,2'b00,0,1));
        tbl.push_back(mk(0,2'b11,2'b00,1,2,0,0,0,0, 2'b01,1,2,0,0,2'b01,32'hA0000001,1));
        tbl.push_back(mk(0,2'b11,2'b00,1,2,0,0,0,0, 2'b10,1,1,0,0,2'b10,32'hA0000002,1));
        tbl.push_back(mk(0,2'b00,2'b00,1,2,0,0,0,0, 2'b00,1,2,0,0,2'b01,32'hA0000001,1));
        tbl.push_back(mk(0,2'b00,2'b00,1,2,0,0,0,0, 2'b00,0,0,0,0,2'b10,32'hA0000002,0));
        // lock held by requester 1
        tbl.push_back(mk(0,2'b11,2'b00,4,6,0,0,0,0, 2'b01,0,0,0,0,2'b00,0,0));
        tbl.push_back(mk(0,2'b11,2'b10,4,6,0,0,0,0, 2'b10,1,4,0,0,2'b00,0,1));
        tbl.push_back(mk(0,2'b11,2'b10,4,6,0,0,0,0, 2'b10,1,6,0,0,2'b01,32'hA0000004,1));
        tbl.push_back(mk(0,2'b11,2'b10,4,6,0,0,0,0, 2'b10,1,6,0,0,2'b10,32'hA0000006,1));
        tbl.push_back(mk(0,2'b11,2'b00,4,6,0,0,0,0, 2'b01,1,6,0,0,2'b10,32'hA0000006,1));
        tbl.push_back(mk(0,2'b00,2'b00,4,6,0,0,0,0, 2'b00,1,4,0,0,2'b10,32'hA0000006,1));
        tbl.push_back(mk(0,2'b00,2'b00,4,6,0,0,0,0, 2'b00,0,0,0,0,2'b01,32'hA0000004,0));
        tbl.push_back(mk(0,2'b00,2'b00,4,6,0,0,0,0, 2'b00,0,0,0,0,2'b00,0,0));
        // byte-enabled write, then read back the merged word
        tbl.push_back(mk(0,2'b10,2'b00,0,5,0,4'b0101,0,32'h11223344, 2'b10,0,0,0,0,2'b00,0,0));
        tbl.push_back(mk(0,2'b00,2'b00,0,5,0,0,0,0, 2'b00,1,5,4'b0101,32'h11223344,2'b00,0,1));
        tbl.push_back(mk(0,2'b00,2'b00,0,5,0,0,0,0, 2'b00,0,0,0,0,2'b10,32'hA0000005,0));
        tbl.push_back(mk(0,2'b01,2'b00,5,0,0,0,0,0, 2'b01,0,0,0,0,2'b00,0,0));
        tbl.push_back(mk(0,2'b00,2'b00,5,0,0,0,0,0, 2'b00,1,5,0,0,2'b00,0,1));
        tbl.push_back(mk(0,2'b00,2'b00,5,0,0,0,0,0, 2'b00,0,0,0,0,2'b01,32'hA0220044,0));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.rst, v.valid, v.lock, v.a0, v.a1, v.we0, v.we1, v.wd0, v.wd1);
            #1;
            chk($sformatf("row%0d ready", i), 32'(req_ready), 32'(v.e_ready));
            chk($sformatf("row%0d en", i),    32'(en),        32'(v.e_en));
            chk($sformatf("row%0d we", i),    32'(we),        32'(v.e_we));
            chk($sformatf("row%0d rv", i),    32'(rsp_valid), 32'(v.e_rv));
            chk($sformatf("row%0d rdata", i), rsp_data,       v.e_rd);
            if (v.cad) begin
                chk($sformatf("row%0d addr", i), 32'(addr), 32'(v.e_addr));
                chk($sformatf("row%0d wdata", i), wr_data,  v.e_wd);
            end
            next_cycle();
        end

        // Idle for 10 cycles; requester 0 won last, so requester 1 goes next.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 2'b00, 2'b00, 4'd7, 4'd8, 4'h0, 4'h0, 32'h0, 32'h0);
            #1;
            chk_quiet($sformatf("idle%0d", i));
            next_cycle();
        end
        drive(1'b0, 2'b11, 2'b00, 4'd7, 4'd8, 4'h0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("idle last held ready", 32'(req_ready), 32'h2);
        next_cycle();

        // Reset lands while two transfers are in flight.
        #1;
        chk("mid t ready", 32'(req_ready), 32'h1);
        chk("mid t en",    32'(en),        32'h1);
        chk("mid t addr",  32'(addr),      32'h8);
        next_cycle();
        drive(1'b1, 2'b11, 2'b00, 4'd7, 4'd8, 4'h0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("mid rst ready", 32'(req_ready), 32'h0);
        chk("mid rst en",    32'(en),        32'h0);
        chk("mid rst addr",  32'(addr),      32'h0);
        chk("mid rst rv",    32'(rsp_valid), 32'h0);
        chk("mid rst rdata", rsp_data,       32'h0);
        next_cycle();
        for (int i = 2; i <= 5; i++) begin
            drive(1'b0, 2'b00, 2'b00, 4'd7, 4'd8, 4'h0, 4'h0, 32'h0, 32'h0);
            #1;
            chk_quiet($sformatf("post rst t+%0d", i));
            next_cycle();
        end
        drive(1'b0, 2'b11, 2'b00, 4'd7, 4'd8, 4'h0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("post rst priority", 32'(req_ready), 32'h1);
        next_cycle();
        drive(1'b0, 2'b00, 2'b00, 4'd7, 4'd8, 4'h0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("post rst en",   32'(en),   32'h1);
        chk("post rst addr", 32'(addr), 32'h7);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
